// File: rtl/concat_packer.sv
// Packs 1..IN_W-bit fields MSB-first into OUT_W-bit words; a flush emits the zero-padded tail.
// Accept-to-word latency 2 cycles; in_ready drops while the accumulator holds a full word it cannot move out.
module concat_packer #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int LEN_W = $clog2(IN_W + 1),
    parameter int CNT_W = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_bits
);
    localparam int ACC_W = OUT_W + IN_W - 1;
    localparam int AC_W  = $clog2(ACC_W + 1);

    typedef enum logic {ACCUM, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [AC_W-1:0]  cnt, cnt_nxt;
    logic [AC_W-1:0]  len_c;
    logic [AC_W-1:0]  shamt;
    logic [ACC_W-1:0] field;
    logic [OUT_W-1:0] top;
    logic             accept;
    logic             load_ok;
    logic             full_word;
    logic             tail_word;

    assign len_c     = (in_len > LEN_W'(IN_W)) ? AC_W'(IN_W) : AC_W'(in_len);
    assign field     = ACC_W'(in_data) & ~({ACC_W{1'b1}} << len_c);
    // Valid bits sit left-aligned in acc; the new field lands just below them.
    assign shamt     = AC_W'(ACC_W) - cnt - len_c;
    assign top       = acc[ACC_W-1 -: OUT_W];

    assign in_ready  = (state == ACCUM) && (cnt < AC_W'(OUT_W));
    assign accept    = in_valid && in_ready;
    assign load_ok   = !out_valid || out_ready;
    assign full_word = load_ok && (cnt >= AC_W'(OUT_W));
    assign tail_word = load_ok && (state == FLUSH) && (cnt != '0) && (cnt < AC_W'(OUT_W));

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        if (accept) begin
            acc_nxt = acc | (field << shamt);
            cnt_nxt = cnt + len_c;
            if (in_flush) begin
                state_nxt = FLUSH;
            end
        end else if (full_word) begin
            acc_nxt = acc << OUT_W;
            cnt_nxt = cnt - AC_W'(OUT_W);
        end else if (tail_word) begin
            acc_nxt = '0;
            cnt_nxt = '0;
        end
        if ((state == FLUSH) && (cnt_nxt == '0)) begin
            state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bits  <= '0;
        end else if (full_word) begin
            out_valid <= 1'b1;
            out_data  <= top;
            out_bits  <= CNT_W'(OUT_W);
        end else if (tail_word) begin
            out_valid <= 1'b1;
            out_data  <= top & ~({OUT_W{1'b1}} >> cnt);
            out_bits  <= CNT_W'(cnt);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_concat_packer.sv
// Directed and randomized bench for concat_packer against a bit-queue reference model.
module tb_concat_packer;
    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int LEN_W = 4;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [LEN_W-1:0] in_len;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_bits;

    concat_packer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bits  (out_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit             bq[$];
    logic [15:0]    wq[$];
    int             nq[$];
    logic [15:0]    last_data;
    int             last_bits;
    bit             hold_pending;
    logic [15:0]    held_d;
    logic [4:0]     held_n;
    bit             rand_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a plain bit stream; every 16 bits form a word, a flush pads the rest.
    task automatic model_accept(input logic [7:0] d, input logic [3:0] l, input logic f);
        int n;
        int k;
        logic [15:0] w;
        n = (l > 8) ? 8 : int'(l);
        for (int i = n - 1; i >= 0; i--) bq.push_back(d[i]);
        while (bq.size() >= 16) begin
            w = '0;
            for (int i = 0; i < 16; i++) w = {w[14:0], bq.pop_front()};
            wq.push_back(w);
            nq.push_back(16);
        end
        if (f && bq.size() > 0) begin
            k = bq.size();
            w = '0;
            for (int i = 0; i < 16; i++) w = {w[14:0], (i < k) ? bq.pop_front() : 1'b0};
            wq.push_back(w);
            nq.push_back(k);
        end
    endtask

    task automatic tick();
        bit ih;
        bit oh;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        ih = in_valid && in_ready;
        oh = out_valid && out_ready;
        if (hold_pending) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held_d);
            chk("hold_bits", out_bits, held_n);
        end
        hold_pending = out_valid && !out_ready;
        held_d = out_data;
        held_n = out_bits;
        if (oh) begin
            chk("word_expected", wq.size() > 0, 1);
            if (wq.size() > 0) begin
                chk("word_data", out_data, wq.pop_front());
                chk("word_bits", out_bits, nq.pop_front());
            end
            last_data = out_data;
            last_bits = out_bits;
        end
        if (ih) model_accept(in_data, in_len, in_flush);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] l, input logic f);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        in_flush = f;
        while (!done && n < 200) begin
            done = in_ready;
            tick();
            n++;
        end
        chk("send_accepted", done, 1);
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wq.size() > 0 || out_valid) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_done", wq.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_len = '0;
        in_flush = 1'b0;
        out_ready = 1'b0;
        rand_rdy = 0;
        hold_pending = 0;
        last_data = '0;
        last_bits = 0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_bits", out_bits, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        // Aligned pack and two-cycle latency
        send(8'hAB, 4'd8, 1'b0);
        send(8'hCD, 4'd8, 1'b0);
        chk("aligned_rdy_low", in_ready, 0);
        chk("aligned_vld_early", out_valid, 0);
        tick();
        chk("aligned_vld", out_valid, 1);
        chk("aligned_rdy_back", in_ready, 1);
        chk("aligned_data", out_data, 16'hABCD);
        chk("aligned_bits", out_bits, 16);
        drain();

        // Straddling fields followed by a zero-length flush
        send(8'h15, 4'd5, 1'b0);
        send(8'h3C, 4'd7, 1'b0);
        send(8'h2A, 4'd6, 1'b0);
        send(8'h00, 4'd0, 1'b1);
        drain();
        chk("straddle_tail_data", last_data, 16'h8000);
        chk("straddle_tail_bits", last_bits, 2);
        chk("straddle_rdy", in_ready, 1);

        // Empty flush
        send(8'h00, 4'd0, 1'b1);
        chk("eflush_rdy_low", in_ready, 0);
        chk("eflush_no_vld", out_valid, 0);
        tick();
        chk("eflush_rdy_back", in_ready, 1);
        chk("eflush_no_vld2", out_valid, 0);

        // Length clamp
        send(8'hFF, 4'd12, 1'b0);
        send(8'h00, 4'd8, 1'b0);
        drain();
        chk("clamp_data", last_data, 16'hFF00);

        // Backpressure with a full accumulator behind a held word
        out_ready = 1'b0;
        send(8'hAB, 4'd8, 1'b0);
        send(8'hCD, 4'd8, 1'b0);
        tick();
        send(8'h12, 4'd8, 1'b0);
        send(8'h34, 4'd8, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("bp_rdy_low", in_ready, 0);
            chk("bp_data", out_data, 16'hABCD);
            tick();
        end
        out_ready = 1'b1;
        drain();
        chk("bp_last", last_data, 16'h1234);

        // Asynchronous reset while a word is pending and 5 bits are buffered
        out_ready = 1'b0;
        send(8'hAB, 4'd8, 1'b0);
        send(8'hCD, 4'd8, 1'b0);
        tick();
        send(8'h1F, 4'd5, 1'b0);
        chk("pre_rst_vld", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_bits", out_bits, 0);
        bq.delete();
        wq.delete();
        nq.delete();
        hold_pending = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'h12, 4'd8, 1'b0);
        send(8'h34, 4'd8, 1'b0);
        send(8'h00, 4'd0, 1'b1);
        drain();
        chk("arst_after_data", last_data, 16'h1234);
        chk("arst_after_bits", last_bits, 16);

        // Randomized fields, lengths, flushes and output stalls
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom), 4'($urandom_range(0, 12)), $urandom_range(0, 7) == 0);
        end
        send(8'h00, 4'd0, 1'b1);
        drain();
        rand_rdy = 0;
        out_ready = 1'b1;
        chk("rand_words_left", wq.size(), 0);
        chk("rand_bits_left", bq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
